tea_core: RTL and testbench

Parametrised TEA block cipher engine that encrypts or decrypts one 64-bit block per transaction, one Feistel cycle (both halves) per clock. It replaces the fixed-function, fixed-key, bit-serial encrypt module. It adds a runtime key, encrypt/decrypt mode, a configurable round count and valid/ready handshakes on both sides. It sits between a block source (UART/FIFO front end) and a result sink.

---
 rtl/tea_pkg.sv | 32 +++
 rtl/tea_round.sv | 40 ++++
 rtl/tea_core.sv | 123 ++++++++++++
 tb/tb_tea_core.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA cipher engine.
// Holds the FSM encoding, key-schedule constant and round mixing helper.
package tea_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

   // Elaboration-time start value of the running sum when decrypting.
   function automatic logic [31:0] dec_init_sum(
      input logic [31:0] delta,
      input int unsigned rounds
   );
      logic [63:0] p;
      p = {32'd0, delta} * 64'(rounds);
      return p[31:0];
   endfunction

   function automatic logic [31:0] tea_mix(
      input logic [31:0] v,
      input logic [31:0] s,
      input logic [31:0] ka,
      input logic [31:0] kb
   );
      return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
   endfunction

endpackage

// File: rtl/tea_round.sv
// One combinational TEA Feistel cycle (both halves).
// Encrypt advances the sum first; decrypt uses the current sum then retreats.
module tea_round
   import tea_pkg::*;
#(
   parameter logic [31:0] DELTA = TEA_DELTA
) (
   input  logic [31:0]  v0_i,
   input  logic [31:0]  v1_i,
   input  logic [31:0]  sum_i,
   input  logic [127:0] key_i,
   input  logic         decrypt_i,
   output logic [31:0]  v0_o,
   output logic [31:0]  v1_o,
   output logic [31:0]  sum_o
);

   logic [31:0] k0, k1, k2, k3;

   assign k0 = key_i[127:96];
   assign k1 = key_i[95:64];
   assign k2 = key_i[63:32];
   assign k3 = key_i[31:0];

   always_comb begin
      v0_o  = v0_i;
      v1_o  = v1_i;
      sum_o = sum_i;
      if (decrypt_i) begin
         v1_o  = v1_i - tea_mix(v0_i, sum_i, k2, k3);
         v0_o  = v0_i - tea_mix(v1_o, sum_i, k0, k1);
         sum_o = sum_i - DELTA;
      end else begin
         sum_o = sum_i + DELTA;
         v0_o  = v0_i + tea_mix(v1_i, sum_o, k0, k1);
         v1_o  = v1_i + tea_mix(v0_o, sum_o, k2, k3);
      end
   end

endmodule

// File: rtl/tea_core.sv
// TEA encrypt/decrypt engine, one Feistel cycle per clock.
// Valid/ready on both sides; runtime key, mode and abort.
module tea_core
   import tea_pkg::*;
#(
   parameter int unsigned ROUNDS = 32,
   parameter logic [31:0] DELTA  = TEA_DELTA
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         decrypt,
   input  logic [31:0]  v0_in,
   input  logic [31:0]  v1_in,
   input  logic [127:0] key,
   input  logic         abort,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  v0_out,
   output logic [31:0]  v1_out,
   output logic [5:0]   round
);

   localparam logic [31:0] DEC_SUM = dec_init_sum(DELTA, ROUNDS);
   localparam logic [5:0]  LAST    = 6'(ROUNDS - 1);

   state_t       state_q, state_d;
   logic [31:0]  v0_q, v0_d;
   logic [31:0]  v1_q, v1_d;
   logic [31:0]  sum_q, sum_d;
   logic [127:0] key_q, key_d;
   logic         dec_q, dec_d;
   logic [5:0]   round_q, round_d;

   logic [31:0]  r_v0, r_v1, r_sum;

   tea_round #(
      .DELTA(DELTA)
   ) u_round (
      .v0_i     (v0_q),
      .v1_i     (v1_q),
      .sum_i    (sum_q),
      .key_i    (key_q),
      .decrypt_i(dec_q),
      .v0_o     (r_v0),
      .v1_o     (r_v1),
      .sum_o    (r_sum)
   );

   always_comb begin
      state_d = state_q;
      v0_d    = v0_q;
      v1_d    = v1_q;
      sum_d   = sum_q;
      key_d   = key_q;
      dec_d   = dec_q;
      round_d = round_q;
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               v0_d    = v0_in;
               v1_d    = v1_in;
               key_d   = key;
               dec_d   = decrypt;
               sum_d   = decrypt ? DEC_SUM : 32'd0;
               round_d = 6'd0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else begin
               v0_d  = r_v0;
               v1_d  = r_v1;
               sum_d = r_sum;
               // Counter parks on the last round rather than wrapping.
               if (round_q == LAST) begin
                  state_d = ST_DONE;
               end else begin
                  round_d = round_q + 6'd1;
               end
            end
         end
         ST_DONE: begin
            if (abort || out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         v0_q    <= '0;
         v1_q    <= '0;
         sum_q   <= '0;
         key_q   <= '0;
         dec_q   <= 1'b0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         v0_q    <= v0_d;
         v1_q    <= v1_d;
         sum_q   <= sum_d;
         key_q   <= key_d;
         dec_q   <= dec_d;
         round_q <= round_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign v0_out    = v0_q;
   assign v1_out    = v1_q;
   assign round     = round_q;

endmodule

// File: tb/tb_tea_core.sv
// Randomized self-checking bench for tea_core.
// Two instances: default 32 rounds and an 8-round variant.
module tb_tea_core;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [1:0]   iv;
   logic [1:0]   ordy;
   logic         abort;
   logic         dec_i;
   logic [31:0]  v0_i, v1_i;
   logic [127:0] key_i;

   logic         in_rdy [2];
   logic         ovld [2];
   logic [31:0]  v0o [2];
   logic [31:0]  v1o [2];
   logic [5:0]   rnd [2];

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tea_core #(.ROUNDS(32)) u_dut32 (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (iv[0]),
      .in_ready (in_rdy[0]),
      .decrypt  (dec_i),
      .v0_in    (v0_i),
      .v1_in    (v1_i),
      .key      (key_i),
      .abort    (abort),
      .out_valid(ovld[0]),
      .out_ready(ordy[0]),
      .v0_out   (v0o[0]),
      .v1_out   (v1o[0]),
      .round    (rnd[0])
   );

   tea_core #(.ROUNDS(8)) u_dut8 (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (iv[1]),
      .in_ready (in_rdy[1]),
      .decrypt  (dec_i),
      .v0_in    (v0_i),
      .v1_in    (v1_i),
      .key      (key_i),
      .abort    (abort),
      .out_valid(ovld[1]),
      .out_ready(ordy[1]),
      .v0_out   (v0o[1]),
      .v1_out   (v1o[1]),
      .round    (rnd[1])
   );

   function automatic logic [63:0] tea_ref(
      input bit dec,
      input logic [31:0] a0,
      input logic [31:0] b0,
      input logic [127:0] k,
      input int n
   );
      logic [31:0] a, b, sum, k0, k1, k2, k3;
      a = a0;
      b = b0;
      k0 = k[127:96];
      k1 = k[95:64];
      k2 = k[63:32];
      k3 = k[31:0];
      sum = 32'd0;
      if (dec)
         for (int i = 0; i < n; i++) sum = sum + 32'h9E3779B9;
      for (int i = 0; i < n; i++) begin
         if (!dec) begin
            sum = sum + 32'h9E3779B9;
            a = a + (((b << 4) + k0) ^ (b + sum) ^ ((b >> 5) + k1));
            b = b + (((a << 4) + k2) ^ (a + sum) ^ ((a >> 5) + k3));
         end else begin
            b = b - (((a << 4) + k2) ^ (a + sum) ^ ((a >> 5) + k3));
            a = a - (((b << 4) + k0) ^ (b + sum) ^ ((b >> 5) + k1));
            sum = sum - 32'h9E3779B9;
         end
      end
      return {a, b};
   endfunction

   function automatic int nrounds(input int s);
      return (s == 1) ? 8 : 32;
   endfunction

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic scramble();
      dec_i = 1'($urandom);
      v0_i  = $urandom;
      v1_i  = $urandom;
      key_i = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Caller sits 1 time unit after a rising edge with the DUT idle.
   task automatic start(input int s, input bit dec, input logic [31:0] a,
                        input logic [31:0] b, input logic [127:0] k);
      dec_i = dec;
      v0_i  = a;
      v1_i  = b;
      key_i = k;
      iv[s] = 1'b1;
      @(posedge clk);
      #1;
      iv[s] = 1'b0;
      scramble();
   endtask

   task automatic wait_valid(input int s, output int lat);
      lat = 0;
      while (!ovld[s] && lat < 300) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handoff(input int s);
      ordy[s] = 1'b1;
      @(posedge clk);
      #1;
      ordy[s] = 1'b0;
      check("handoff_in_ready", 64'(in_rdy[s]), 64'd1);
      check("handoff_out_valid", 64'(ovld[s]), 64'd0);
   endtask

   task automatic run(input int s, input bit dec, input logic [31:0] a,
                      input logic [31:0] b, input logic [127:0] k,
                      output logic [63:0] res, output int lat);
      start(s, dec, a, b, k);
      wait_valid(s, lat);
      res = {v0o[s], v1o[s]};
      handoff(s);
   endtask

   task automatic check_reset_vals(input string tag);
      for (int s = 0; s < 2; s++) begin
         check({tag, "_in_ready"}, 64'(in_rdy[s]), 64'd1);
         check({tag, "_out_valid"}, 64'(ovld[s]), 64'd0);
         check({tag, "_data"}, {v0o[s], v1o[s]}, 64'd0);
         check({tag, "_round"}, 64'(rnd[s]), 64'd0);
      end
   endtask

   initial begin
      logic [63:0]  res, res2, exp;
      logic [31:0]  a, b;
      logic [127:0] k;
      bit           dec;
      int           lat, s;

      iv = '0;
      ordy = '0;
      abort = 1'b0;
      dec_i = 1'b0;
      v0_i = '0;
      v1_i = '0;
      key_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Known answers, default rounds
      run(0, 1'b0, 32'd0, 32'd0, 128'd0, res, lat);
      check("kat_enc", res, 64'h41EA3A0A_94BAA940);
      check("kat_enc_lat", 64'(lat), 64'd32);
      run(0, 1'b1, 32'h41EA3A0A, 32'h94BAA940, 128'd0, res, lat);
      check("kat_dec", res, 64'd0);
      check("kat_dec_lat", 64'(lat), 64'd32);

      // Round trip on the 8-round instance
      k = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      run(1, 1'b0, 32'hDEADBEEF, 32'h01234567, k, res, lat);
      check("rt_enc", res, tea_ref(1'b0, 32'hDEADBEEF, 32'h01234567, k, 8));
      check("rt_enc_lat", 64'(lat), 64'd8);
      run(1, 1'b1, res[63:32], res[31:0], k, res2, lat);
      check("rt_dec", res2, 64'hDEADBEEF_01234567);
      check("rt_dec_lat", 64'(lat), 64'd8);

      // Backpressure with an ignored in_valid pulse
      a = $urandom;
      b = $urandom;
      k = {$urandom, $urandom, $urandom, $urandom};
      exp = tea_ref(1'b0, a, b, k, 32);
      start(0, 1'b0, a, b, k);
      wait_valid(0, lat);
      check("bp_lat", 64'(lat), 64'd32);
      for (int i = 0; i < 10; i++) begin
         iv[0] = (i == 3);
         @(posedge clk);
         #1;
         check("bp_hold_data", {v0o[0], v1o[0]}, exp);
         check("bp_in_ready", 64'(in_rdy[0]), 64'd0);
      end
      iv[0] = 1'b0;
      handoff(0);
      @(posedge clk);
      #1;
      check("bp_no_capture", 64'(ovld[0]), 64'd0);
      check("bp_still_idle", 64'(in_rdy[0]), 64'd1);
      run(0, 1'b1, a, b, k, res, lat);
      check("bp_next", res, tea_ref(1'b1, a, b, k, 32));

      // Abort at round 10
      start(0, 1'b0, $urandom, $urandom, 128'd5);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      check("abort_round", 64'(rnd[0]), 64'd10);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_in_ready", 64'(in_rdy[0]), 64'd1);
      check("abort_out_valid", 64'(ovld[0]), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("abort_stays_idle", 64'(in_rdy[0]), 64'd1);

      // Asynchronous reset at round 5, then a clean job
      start(0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 128'd7);
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      check("rst_round", 64'(rnd[0]), 64'd5);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      run(0, 1'b0, 32'd0, 32'd0, 128'd0, res, lat);
      check("post_rst_kat", res, 64'h41EA3A0A_94BAA940);

      // Abort together with out_ready in DONE
      start(1, 1'b0, $urandom, $urandom, 128'd9);
      wait_valid(1, lat);
      check("simul_lat", 64'(lat), 64'd8);
      abort = 1'b1;
      ordy[1] = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      ordy[1] = 1'b0;
      check("simul_in_ready", 64'(in_rdy[1]), 64'd1);
      check("simul_out_valid", 64'(ovld[1]), 64'd0);
      repeat (4) @(posedge clk);
      #1;
      check("simul_no_dup", 64'(ovld[1]), 64'd0);

      // Randomized jobs against the reference model
      for (int i = 0; i < 10; i++) begin
         s = i % 2;
         dec = 1'($urandom);
         a = $urandom;
         b = $urandom;
         k = {$urandom, $urandom, $urandom, $urandom};
         run(s, dec, a, b, k, res, lat);
         check("rand_result", res, tea_ref(dec, a, b, k, nrounds(s)));
         check("rand_lat", 64'(lat), 64'(nrounds(s)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
